// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback scoreboard.
// Holds register count, select/data widths and pending-counter width.
package rf_pkg;

    localparam int NREG  = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [AW-1:0] reg_sel_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rf_pend_cnt.sv
// Saturating up/down pending-write counter for one register.
// Ports: clk, rst_n, inc_i, dec_i -> count_o, underflow_o (dec at zero).
module rf_pend_cnt
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; both ends clamp.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o     = cnt_q;
    assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Writeback arbiter (mem over alu) onto the registered RF write port,
// with per-register pending counters, RAW stall and same-cycle bypass.
// Ports: iss_* issue, alu_*/mem_* producers, write/writeregsel/writedata,
// read1/2regsel sources, rd1/2_fwd bypass, stall, sticky err.
module rf_wb_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_dst,
    output logic          iss_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_dst,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_dst,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          write,
    output logic [AW-1:0] writeregsel,
    output logic [DW-1:0] writedata,
    input  logic [AW-1:0] read1regsel,
    input  logic [AW-1:0] read2regsel,
    output logic          rd1_fwd,
    output logic          rd2_fwd,
    output logic          stall,
    output logic          err
);

    logic             write_q, write_d;
    reg_sel_t         sel_q, sel_d;
    reg_data_t        data_q, data_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  unf;

    logic             hit1, hit2;
    logic             haz1, haz2;
    logic             iss_fire;

    assign mem_ready = 1'b1;
    assign alu_ready = !mem_valid;

    // Winner is registered; select/data hold when nothing is accepted.
    always_comb begin
        write_d = mem_valid || alu_valid;
        sel_d   = sel_q;
        data_d  = data_q;
        if (mem_valid) begin
            sel_d  = mem_dst;
            data_d = mem_data;
        end else if (alu_valid) begin
            sel_d  = alu_dst;
            data_d = alu_data;
        end
        err_d = err_q || (|unf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // A retire to the same register frees the slot this cycle.
    assign iss_ready = (cnt[iss_dst] != CNT_MAX)
                    || (write_q && sel_q == iss_dst);
    assign iss_fire  = iss_valid && iss_ready;

    for (genvar i = 0; i < NREG; i++) begin : g_cnt
        assign inc[i] = iss_fire && (iss_dst == AW'(i));
        assign dec[i] = write_q && (sel_q == AW'(i));

        rf_pend_cnt u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc[i]),
            .dec_i       (dec[i]),
            .count_o     (cnt[i]),
            .underflow_o (unf[i])
        );
    end

    // The write in flight covers one pending count via the bypass.
    assign hit1 = write_q && (sel_q == read1regsel);
    assign hit2 = write_q && (sel_q == read2regsel);
    assign haz1 = cnt[read1regsel] > CNT_W'(hit1);
    assign haz2 = cnt[read2regsel] > CNT_W'(hit2);

    assign rd1_fwd     = hit1;
    assign rd2_fwd     = hit2;
    assign stall       = haz1 || haz2;
    assign write       = write_q;
    assign writeregsel = sel_q;
    assign writedata   = data_q;
    assign err         = err_q;

endmodule
